// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: word/address sizing, NOP encoding, FSM states.
package instruction_loader_pkg;

    localparam int          INSTR_WIDTH   = 32;
    localparam int          IL_ADDR_WIDTH = 10;
    localparam int          IRAM_DEPTH    = 71;
    localparam logic [31:0] NOP_INSTR     = 32'h5C00_0000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// Host byte stream (valid/ready) plus the instruction RAM write port.
interface instruction_loader_if
    import instruction_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = IL_ADDR_WIDTH
) ();

    logic [7:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [INSTR_WIDTH-1:0] wr_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Collects bytes big-endian; word_full flags the byte that completes a word (word_dat valid then).
// Combinational output, no backpressure of its own: the caller only pulses byte_vld on accepted bytes.
module word_assembler
    import instruction_loader_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   byte_vld,
    input  logic [7:0]             byte_dat,
    output logic [INSTR_WIDTH-1:0] word_dat,
    output logic                   word_full
);

    // Only the first three bytes need storing; the fourth arrives with word_full.
    logic [INSTR_WIDTH-9:0] r_shift;
    logic [1:0]             r_cnt;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_shift <= '0;
            r_cnt   <= 2'd0;
        end else if (byte_vld) begin
            r_shift <= {r_shift[INSTR_WIDTH-17:0], byte_dat};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

    assign word_dat  = {r_shift, byte_dat};
    assign word_full = byte_vld && (r_cnt == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed big-endian program into instruction RAM; one RAM write 1 cycle after each 4th byte.
// in_ready is high only while expecting length/data bytes; in_valid gaps stall with no lost state.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = IL_ADDR_WIDTH,
    parameter int MAX_WORDS  = IRAM_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    instruction_loader_if.slave  bus,
    output logic                 cpu_halt,
    output logic                 done,
    output logic                 load_error
);

    loader_state_t          r_state;
    loader_state_t          w_next;
    logic [15:0]            r_len;
    logic [15:0]            r_word_cnt;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [INSTR_WIDTH-1:0] r_wr_data;

    logic                   w_in_ready;
    logic                   w_xfer;
    logic                   w_start_ok;
    logic [15:0]            w_len;
    logic [INSTR_WIDTH-1:0] w_word;
    logic                   w_word_full;
    logic                   w_wr_en;
    logic                   w_halt;
    logic                   w_done;
    logic                   w_err;

    assign w_in_ready = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == DATA);
    assign w_xfer     = w_in_ready && bus.in_valid;
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
    assign w_len      = {r_len[15:8], bus.in_data};

    word_assembler u_asm (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_start_ok),
        .byte_vld  (w_xfer && (r_state == DATA)),
        .byte_dat  (bus.in_data),
        .word_dat  (w_word),
        .word_full (w_word_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_wr_en = 1'b0;
        w_halt  = 1'b0;
        w_done  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            IDLE: ;
            LEN_HI: begin
                w_halt = 1'b1;
                if (w_xfer) w_next = LEN_LO;
            end
            LEN_LO: begin
                w_halt = 1'b1;
                if (w_xfer) begin
                    if (w_len == 16'd0)                  w_next = DONE;
                    else if (32'(w_len) > MAX_WORDS)     w_next = ERROR;
                    else                                 w_next = DATA;
                end
            end
            DATA: begin
                w_halt = 1'b1;
                if (w_word_full) w_next = WRITE;
            end
            WRITE: begin
                w_halt  = 1'b1;
                w_wr_en = 1'b1;
                w_next  = ((r_word_cnt + 16'd1) == r_len) ? DONE : DATA;
            end
            DONE:    w_done = 1'b1;
            ERROR:   w_err  = 1'b1;
            default: w_next = IDLE;
        endcase
        if (w_start_ok) w_next = LEN_HI;
    end

    // wr_addr/wr_data are latched with the completing byte so they stay frozen outside WRITE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_len      <= '0;
            r_word_cnt <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else if (w_start_ok) begin
            r_word_cnt <= '0;
            r_wr_addr  <= '0;
        end else begin
            if (w_xfer && (r_state == LEN_HI)) r_len[15:8] <= bus.in_data;
            if (w_xfer && (r_state == LEN_LO)) r_len[7:0]  <= bus.in_data;
            if (w_word_full) begin
                r_wr_data <= w_word;
                r_wr_addr <= r_word_cnt[ADDR_WIDTH-1:0];
            end
            if (r_state == WRITE) r_word_cnt <= r_word_cnt + 16'd1;
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.wr_en    = w_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign cpu_halt     = w_halt;
    assign done         = w_done;
    assign load_error   = w_err;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: driver pushes expected RAM writes into a queue,
// a negedge monitor pops and checks address, data, write latency and halt on every wr_en.
module tb_instruction_loader;

    logic clock;
    logic reset;
    logic start;
    logic cpu_halt;
    logic done;
    logic load_error;

    instruction_loader_if #(.ADDR_WIDTH(10)) bus ();

    instruction_loader #(.ADDR_WIDTH(10), .MAX_WORDS(71)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .bus        (bus),
        .cpu_halt   (cpu_halt),
        .done       (done),
        .load_error (load_error)
    );

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks  = 0;
    int  errors  = 0;
    int  cyc     = 0;
    int  last_hs = -100;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.wr_addr, bus.wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                chk("wr_data", bus.wr_data, e.data);
                chk("wr_latency", 32'(cyc), 32'(last_hs + 1));
                chk("halt_in_write", 32'(cpu_halt), 32'd1);
            end
        end
    end

    // All tasks start and end at #1 after a rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        got = 1'b0;
        bus.in_valid = 1'b0;
        repeat (gap) step();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 50; t++) begin
            if (bus.in_ready === 1'b1) begin
                last_hs = cyc;
                got = 1'b1;
            end
            step();
            if (got) break;
        end
        bus.in_valid = 1'b0;
        if (!got) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input logic exp_done);
        for (int t = 0; t < 40; t++) begin
            if (done || load_error) break;
            step();
        end
        chk(name, 32'(done), 32'(exp_done));
        chk({name, "_err"}, 32'(load_error), 32'(!exp_done));
        chk({name, "_halt"}, 32'(cpu_halt), 32'd0);
    endtask

    task automatic push_wr(input logic [9:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    logic [7:0]  prog1 [10] = '{8'h00, 8'h02, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h48, 8'h00, 8'h00, 8'h07};
    logic [31:0] words5 [5] = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF01, 32'h0203_0405};

    initial begin
        logic [31:0] w;
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) step();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_wr_en",    32'(bus.wr_en),    32'd0);
        chk("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
        chk("rst_wr_data",  bus.wr_data,       32'd0);
        chk("rst_halt",     32'(cpu_halt),     32'd0);
        chk("rst_done",     32'(done),         32'd0);
        chk("rst_err",      32'(load_error),   32'd0);
        reset = 1'b0;
        step();

        // Two-word program, in_valid always high.
        pulse_start();
        chk("t1_halt_after_start",  32'(cpu_halt),     32'd1);
        chk("t1_ready_after_start", 32'(bus.in_ready), 32'd1);
        push_wr(10'd0, 32'h5C00_0000);
        push_wr(10'd1, 32'h4800_0007);
        foreach (prog1[i]) send_byte(prog1[i], 0);
        wait_end("t1_done", 1'b1);
        chk("t1_ready_in_done", 32'(bus.in_ready), 32'd0);

        // Length 72 exceeds the RAM depth.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h48, 0);
        chk("t2_err",   32'(load_error),   32'd1);
        chk("t2_ready", 32'(bus.in_ready), 32'd0);
        chk("t2_halt",  32'(cpu_halt),     32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAB;
        repeat (4) step();
        bus.in_valid = 1'b0;
        chk("t2_err_hold", 32'(load_error), 32'd1);

        // Zero-length program finishes right after the length bytes.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("t3_done", 32'(done),     32'd1);
        chk("t3_halt", 32'(cpu_halt), 32'd0);

        // One word with random gaps between bytes.
        pulse_start();
        push_wr(10'd0, 32'hDEAD_BEEF);
        send_byte(8'h00, int'($urandom_range(5, 0)));
        send_byte(8'h01, int'($urandom_range(5, 0)));
        w = 32'hDEAD_BEEF;
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], int'($urandom_range(5, 0)));
        wait_end("t4_done", 1'b1);

        // Reset in the middle of word 3 of a five-word load.
        pulse_start();
        for (int k = 0; k < 3; k++) push_wr(10'(k), words5[k]);
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        for (int k = 0; k < 3; k++)
            for (int i = 3; i >= 0; i--) send_byte(words5[k][i*8 +: 8], 0);
        send_byte(words5[3][31:24], 0);
        send_byte(words5[3][23:16], 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_rst_ready",   32'(bus.in_ready), 32'd0);
        chk("t5_rst_wr_en",   32'(bus.wr_en),    32'd0);
        chk("t5_rst_wr_addr", 32'(bus.wr_addr),  32'd0);
        chk("t5_rst_wr_data", bus.wr_data,       32'd0);
        chk("t5_rst_halt",    32'(cpu_halt),     32'd0);
        chk("t5_rst_done",    32'(done),         32'd0);
        repeat (5) step();
        chk("t5_writes_left", 32'(exp_q.size()), 32'd0);
        pulse_start();
        push_wr(10'd0, 32'hCAFE_F00D);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        w = 32'hCAFE_F00D;
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 0);
        wait_end("t5_reload_done", 1'b1);

        // Start pulsed mid-DATA is ignored.
        pulse_start();
        push_wr(10'd0, 32'hA1B2_C3D4);
        push_wr(10'd1, 32'h0102_0304);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        pulse_start();
        chk("t6_ready_after_start", 32'(bus.in_ready), 32'd1);
        chk("t6_halt_after_start",  32'(cpu_halt),     32'd1);
        send_byte(8'hC3, 0);
        send_byte(8'hD4, 0);
        send_byte(8'h01, 1);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        wait_end("t6_done", 1'b1);

        // Reset wins over start in the same cycle.
        start = 1'b1;
        reset = 1'b1;
        step();
        start = 1'b0;
        reset = 1'b0;
        chk("t6_rst_start_ready", 32'(bus.in_ready), 32'd0);
        chk("t6_rst_start_done",  32'(done),         32'd0);
        chk("t6_rst_start_halt",  32'(cpu_halt),     32'd0);

        repeat (3) step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10: instruction RAM address width.
REQ-002 The block SHALL have parameter MAX_WORDS, default 71: instruction RAM depth in words.
REQ-003 The block SHALL have the port clock, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the port start, input, 1 bit: one-cycle request to begin a program load.
REQ-006 The block SHALL have the port in_data, input, 8 bits: host byte stream.
REQ-007 The block SHALL have the port in_valid, input, 1 bit: in_data is valid.
REQ-008 The block SHALL have the port in_ready, output, 1 bit: the loader accepts the byte; a transfer occurs when in_valid and in_ready are both high.
REQ-009 The block SHALL have the port wr_en, output, 1 bit: instruction RAM write strobe.
REQ-010 The block SHALL have the port wr_addr, output, ADDR_WIDTH bits: RAM write address.
REQ-011 The block SHALL have the port wr_data, output, 32 bits: instruction word to write.
REQ-012 The block SHALL have the port cpu_halt, output, 1 bit: holds the processor while a load is in progress.
REQ-013 The block SHALL have the port done, output, 1 bit: the last load completed successfully.
REQ-014 The block SHALL have the port load_error, output, 1 bit: the last load was rejected.

Function
REQ-015 The states SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
REQ-016 A start in IDLE, DONE or ERROR SHALL go to LEN_HI, clear done and load_error, zero the word counter and wr_addr, and set cpu_halt.
REQ-017 start in any other state SHALL be ignored.
REQ-018 in_ready SHALL be high only in LEN_HI, LEN_LO and DATA.
REQ-019 The first two accepted bytes SHALL form the 16-bit word count N, high byte first (LEN_HI, then LEN_LO).
REQ-020 After LEN_LO: if N=0, go to DONE; if N>MAX_WORDS, go to ERROR; otherwise go to DATA.
REQ-021 In DATA, four accepted bytes SHALL be assembled big-endian into one word: the first byte goes to bits 31:24.
REQ-022 The fourth accepted byte SHALL cause a transition to WRITE.
REQ-023 WRITE SHALL last exactly one cycle, with wr_en=1, wr_addr=the word index, and wr_data=the assembled word.
REQ-024 The cycle after WRITE, the word index SHALL increment, then go to DONE if index+1=N, else back to DATA.
REQ-025 Latency from the fourth byte's handshake to wr_en SHALL be 1 cycle.
REQ-026 The maximum rate SHALL be one word per 5 cycles.
REQ-027 in_valid low SHALL stall without penalty, and partial byte/word state SHALL be retained.
REQ-028 wr_addr SHALL never reach MAX_WORDS (guaranteed by REQ-020); no wrap-around is permitted.
REQ-029 DONE SHALL drive done=1 and cpu_halt=0, and SHALL hold until start or reset.
REQ-030 ERROR SHALL drive load_error=1 and cpu_halt=0, accept no bytes, write nothing, and hold until start or reset.
REQ-031 wr_en SHALL be 0 in every state except WRITE; outside WRITE, wr_data and wr_addr hold their last values.

Reset
REQ-032 reset SHALL take priority over start and over any handshake in the same cycle.
REQ-033 Reset values SHALL be: state IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_halt=0, done=0, load_error=0, byte and word counters 0.
REQ-034 Reset mid-load SHALL abandon the load immediately; no further writes occur, and words already written remain in RAM.

Structure
REQ-035 The shared package SHALL hold: instruction width 32, ADDR_WIDTH 10, IRAM depth 71, the NOP encoding 32'h5C000000, and the loader state encoding.
REQ-036 One sub-module, word_assembler, SHALL be used: a byte shift register plus a 2-bit byte counter with a word_full flag.
REQ-037 The FSM, the length register and the address counter SHALL live in instruction_loader.

Verification
REQ-038 The bench SHALL cover: start; bytes 00 02 5C 00 00 00 48 00 00 07, in_valid always high -> wr_en at addr 0 data 5C000000, then addr 1 data 48000007; done=1; cpu_halt high from the cycle after start until DONE.
REQ-039 The bench SHALL cover: length 00 48 (72>71) -> load_error=1, in_ready=0, zero writes, cpu_halt=0.
REQ-040 The bench SHALL cover: length 00 00 -> done=1 two accepted bytes after start, with no wr_en.
REQ-041 The bench SHALL cover: N=1, in_valid toggling randomly with gaps of 0-5 cycles between bytes -> exactly one write, of the correct big-endian word, 1 cycle after the 4th handshake.
REQ-042 The bench SHALL cover: reset asserted after the 2nd data byte of word 3 (N=5) -> only addrs 0-2 written, all outputs at reset values next cycle, and a new start/load works normally.
REQ-043 The bench SHALL cover: start pulsed mid-DATA -> ignored, and the load completes unchanged; start and reset in the same cycle -> IDLE.
